contador_alvo_4_bits: RTL and testbench
=======================================

// Module: contador_alvo_4_bits
// PURPOSE
//  Sequential stage wrapped around magnitude_comparator_4_bits.
//  Drives the comparator's A input (contagem) and B input (alvo_reg), then consumes its
//  results (saida_e/saida_plus/saida_less) to step contagem one unit per cycle toward a
//  loaded target. Signals completion when A==B. Used by the counter/adder datapath to
//  seek a programmed value.
// PARAMETERS
//  WIDTH  4  counter/target width; must be 4 when paired with magnitude_comparator_4_bits
// PORTS
//  clk         in   1      single clock, rising edge
//  rst_n       in   1      reset, asynchronous, active-low
//  start       in   1      request: load alvo and begin seeking
//  alvo        in   WIDTH  target value, sampled only when start is accepted
//  abort       in   1      cancel current run
//  saida_e     in   1      comparator A==B (A=contagem, B=alvo_reg)
//  saida_plus  in   1      comparator A>B
//  saida_less  in   1      comparator A<B
//  contagem    out  WIDTH  current count; drives comparator A
//  alvo_reg    out  WIDTH  registered target; drives comparator B
//  ocupado     out  1      high in CARREGA or CONTA
//  pronto      out  1      one-cycle pulse: target reached
//  passos      out  WIDTH  steps taken in current/last run
//  erro        out  1      sticky: comparator flags not one-hot during CONTA
// BEHAVIOUR
//  Reset (rst_n=0, async): state=OCIOSO; contagem, alvo_reg, passos = 0;
//   ocupado, pronto, erro = 0. All outputs are registered, except ocupado, which
//   decodes state.
//  FSM states: OCIOSO, CARREGA, CONTA, FIM.
//  - OCIOSO/FIM with start=1, abort=0: alvo_reg<=alvo, passos<=0, erro<=0 -> CARREGA.
//    Otherwise FIM -> OCIOSO, and OCIOSO holds.
//  - CARREGA: one settle cycle for comparator with the new alvo_reg -> CONTA.
//  - CONTA: evaluates the flags each edge:
//    saida_e only    -> FIM; pronto<=1.
//    saida_less only -> contagem+1, passos+1.
//    saida_plus only -> contagem-1, passos+1.
//    not one-hot     -> erro<=1, OCIOSO; contagem/passos held.
//  - pronto is high exactly during the first (only) cycle of FIM; 0 elsewhere.
//  - contagem is NOT cleared by start; each run seeks from the current value.
//    Motion is monotonic toward the target, so no wrap-around occurs.
//    passos max = 2^WIDTH-1 = 15, which never overflows.
//  - Latency: start sampled at edge 0; distance d=|alvo-contagem|; pronto rises at
//    edge d+2 (d=0 -> edge 2).
//  - start in CARREGA/CONTA is ignored (alvo_reg unchanged).
//  - abort=1 in any state -> OCIOSO next edge. contagem, passos and alvo_reg are held,
//    pronto=0. abort wins over a simultaneous start.
//  - rst_n asserted mid-run clears everything immediately, regardless of clk.
// TESTING
//  1 rst_n=0 pulse, no clk -> all outputs 0, ocupado=0.
//  2 contagem=0, start alvo=9 -> up-counts 0..9; pronto at edge 11; passos=9;
//    ocupado high edges 1-10.
//  3 then start alvo=2 -> down-counts 9..2; pronto at edge 9; passos=7; contagem=2.
//  4 start alvo=2 with contagem=2 -> pronto at edge 2; passos=0; contagem unchanged.
//  5 start alvo=12 from 0; abort when contagem=5 -> OCIOSO; contagem stays 5; no pronto.
//    start+abort same cycle -> stays OCIOSO.
//  6 in CONTA, force saida_e=saida_plus=1 -> erro=1, OCIOSO, contagem held;
//    next start clears erro. rst_n=0 mid-run -> immediate all-zero.

Source files
------------

// File: rtl/contador_alvo_4_bits_if.sv
// Bundle between the target-seeking counter and its surroundings.
//   start / alvo / abort         : command side (driven by the master)
//   saida_e / saida_plus / saida_less : comparator results for A=contagem, B=alvo_reg
//   contagem / alvo_reg          : comparator operands (driven by the counter)
//   ocupado / pronto / passos / erro : status (driven by the counter)
// The counter sits on the slave modport. The master modport is the
// command + comparator side.
interface contador_alvo_4_bits_if #(
    parameter int WIDTH = 4
);
    logic             start;
    logic [WIDTH-1:0] alvo;
    logic             abort;
    logic             saida_e;
    logic             saida_plus;
    logic             saida_less;
    logic [WIDTH-1:0] contagem;
    logic [WIDTH-1:0] alvo_reg;
    logic             ocupado;
    logic             pronto;
    logic [WIDTH-1:0] passos;
    logic             erro;

    modport master (
        output start, alvo, abort, saida_e, saida_plus, saida_less,
        input  contagem, alvo_reg, ocupado, pronto, passos, erro
    );

    modport slave (
        input  start, alvo, abort, saida_e, saida_plus, saida_less,
        output contagem, alvo_reg, ocupado, pronto, passos, erro
    );
endinterface

// File: rtl/contador_alvo_4_bits.sv
// contador_alvo_4_bits
// This block steps a counter one unit per cycle toward a loaded target.
// An external 4-bit magnitude comparator performs the comparisons.
// The counter drives comparator A with contagem and comparator B with alvo_reg.
// It reacts to the equal / greater / less flags that the comparator returns.
// Ports:
//   clk    : rising-edge clock
//   rst_n  : asynchronous, active-low reset
//   cmp    : contador_alvo_4_bits_if.slave. It carries the following signals:
//            - start, alvo, abort: the run request
//            - saida_*: the comparator flags
//            - contagem, alvo_reg: the comparator operands
//            - ocupado, pronto, passos, erro: status
module contador_alvo_4_bits #(
    parameter int WIDTH = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    contador_alvo_4_bits_if.slave  cmp
);

    typedef enum logic [1:0] {
        OCIOSO  = 2'd0,
        CARREGA = 2'd1,
        CONTA   = 2'd2,
        FIM     = 2'd3
    } estado_t;

    estado_t          state_reg, state_next;
    logic [WIDTH-1:0] contagem_reg, contagem_next;
    logic [WIDTH-1:0] alvo_reg_reg, alvo_reg_next;
    logic [WIDTH-1:0] passos_reg, passos_next;
    logic             pronto_reg, pronto_next;
    logic             erro_reg, erro_next;
    logic [2:0]       flags;

    assign flags = {cmp.saida_e, cmp.saida_plus, cmp.saida_less};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg    <= OCIOSO;
            contagem_reg <= '0;
            alvo_reg_reg <= '0;
            passos_reg   <= '0;
            pronto_reg   <= 1'b0;
            erro_reg     <= 1'b0;
        end else begin
            state_reg    <= state_next;
            contagem_reg <= contagem_next;
            alvo_reg_reg <= alvo_reg_next;
            passos_reg   <= passos_next;
            pronto_reg   <= pronto_next;
            erro_reg     <= erro_next;
        end
    end

    always_comb begin
        state_next    = state_reg;
        contagem_next = contagem_reg;
        alvo_reg_next = alvo_reg_reg;
        passos_next   = passos_reg;
        pronto_next   = 1'b0;   // pronto lives only for the single FIM cycle
        erro_next     = erro_reg;

        if (cmp.abort) begin
            // Abort beats everything, including a simultaneous start.
            // The datapath is frozen where it stands.
            state_next = OCIOSO;
        end else begin
            case (state_reg)
                OCIOSO, FIM: begin
                    if (cmp.start) begin
                        alvo_reg_next = cmp.alvo;
                        passos_next   = '0;
                        erro_next     = 1'b0;
                        state_next    = CARREGA;
                    end else begin
                        state_next = OCIOSO;
                    end
                end
                // The new alvo_reg needs one cycle to reach the comparator
                // before its flags can be trusted.
                CARREGA: state_next = CONTA;
                CONTA: begin
                    case (flags)
                        3'b100: begin
                            state_next  = FIM;
                            pronto_next = 1'b1;
                        end
                        3'b001: begin
                            contagem_next = contagem_reg + 1'b1;
                            passos_next   = passos_reg + 1'b1;
                        end
                        3'b010: begin
                            contagem_next = contagem_reg - 1'b1;
                            passos_next   = passos_reg + 1'b1;
                        end
                        default: begin
                            // The comparator contradicted itself.
                            // Stop without moving.
                            erro_next  = 1'b1;
                            state_next = OCIOSO;
                        end
                    endcase
                end
                default: state_next = OCIOSO;
            endcase
        end
    end

    assign cmp.contagem = contagem_reg;
    assign cmp.alvo_reg = alvo_reg_reg;
    assign cmp.passos   = passos_reg;
    assign cmp.pronto   = pronto_reg;
    assign cmp.erro     = erro_reg;
    assign cmp.ocupado  = (state_reg == CARREGA) || (state_reg == CONTA);

endmodule

// File: tb/tb_contador_alvo_4_bits.sv
// Directed bench for contador_alvo_4_bits.
// The bench models the comparator combinationally from the DUT operands.
// force_err can drive contradictory comparator flags.
module tb_contador_alvo_4_bits;

    logic clk;
    logic rst_n;
    logic force_err;
    int   n_checks;
    int   n_fail;

    contador_alvo_4_bits_if #(.WIDTH(4)) cmp_if ();

    contador_alvo_4_bits #(.WIDTH(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .cmp   (cmp_if)
    );

    assign cmp_if.saida_e    = force_err ? 1'b1 : (cmp_if.contagem == cmp_if.alvo_reg);
    assign cmp_if.saida_plus = force_err ? 1'b1 : (cmp_if.contagem >  cmp_if.alvo_reg);
    assign cmp_if.saida_less = force_err ? 1'b0 : (cmp_if.contagem <  cmp_if.alvo_reg);

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Assert start for edge 0. Then return the edge index at which pronto
    // was first seen, or -1 if it never appeared within budget.
    task automatic run_seek(input logic [3:0] target, output int pronto_edge,
                            output bool_busy_ok);
        bit busy_ok;
        pronto_edge = -1;
        busy_ok     = 1'b1;
        @(negedge clk);
        cmp_if.start = 1'b1;
        cmp_if.alvo  = target;
        @(posedge clk);
        #1;
        cmp_if.start = 1'b0;
        for (int e = 1; e <= 40; e++) begin
            if (!cmp_if.ocupado) busy_ok = 1'b0;
            @(posedge clk);
            #1;
            if (cmp_if.pronto) begin
                pronto_edge = e;
                break;
            end
        end
        bool_busy_ok = busy_ok;
    endtask

    task automatic do_reset();
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        rst_n = 1'b1;
        #1;
    endtask

    task automatic test_reset();
        #2;
        rst_n = 1'b0;
        #1;
        n_checks++;
        if ({cmp_if.contagem, cmp_if.alvo_reg, cmp_if.passos} !== 12'h000 ||
            {cmp_if.ocupado, cmp_if.pronto, cmp_if.erro} !== 3'b000) begin
            n_fail++;
            $display("FAIL reset: contagem=%0d alvo_reg=%0d passos=%0d ocupado=%b pronto=%b erro=%b, required all 0",
                     cmp_if.contagem, cmp_if.alvo_reg, cmp_if.passos,
                     cmp_if.ocupado, cmp_if.pronto, cmp_if.erro);
        end
        $display("reset: contagem=%0d ocupado=%b", cmp_if.contagem, cmp_if.ocupado);
        rst_n = 1'b1;
    endtask

    task automatic test_count_up();
        int  pe;
        bit  busy;
        logic [3:0] a_before;
        // start during CONTA must be ignored
        fork
            run_seek(4'd9, pe, busy);
            begin
                repeat (4) @(posedge clk);
                @(negedge clk);
                a_before = cmp_if.alvo_reg;
                cmp_if.start = 1'b1;
                cmp_if.alvo  = 4'd3;
                @(negedge clk);
                cmp_if.start = 1'b0;
                n_checks++;
                if (cmp_if.alvo_reg !== 4'd9) begin
                    n_fail++;
                    $display("FAIL start_ignored: alvo_reg=%0d required 9 (was %0d)",
                             cmp_if.alvo_reg, a_before);
                end
            end
        join
        $display("count_up: target=9 pronto_edge=%0d contagem=%0d passos=%0d",
                 pe, cmp_if.contagem, cmp_if.passos);
        n_checks++;
        if (pe !== 11) begin
            n_fail++;
            $display("FAIL up_latency: pronto edge=%0d required 11", pe);
        end
        n_checks++;
        if (cmp_if.contagem !== 4'd9 || cmp_if.passos !== 4'd9) begin
            n_fail++;
            $display("FAIL up_values: contagem=%0d passos=%0d required 9/9",
                     cmp_if.contagem, cmp_if.passos);
        end
        n_checks++;
        if (busy !== 1'b1 || cmp_if.ocupado !== 1'b0) begin
            n_fail++;
            $display("FAIL up_ocupado: busy_during_run=%b ocupado_in_fim=%b required 1/0",
                     busy, cmp_if.ocupado);
        end
        @(posedge clk);
        #1;
        n_checks++;
        if (cmp_if.pronto !== 1'b0) begin
            n_fail++;
            $display("FAIL pronto_pulse: pronto=%b one cycle after FIM, required 0", cmp_if.pronto);
        end
    endtask

    task automatic test_count_down();
        int pe;
        bit busy;
        run_seek(4'd2, pe, busy);
        $display("count_down: target=2 pronto_edge=%0d contagem=%0d passos=%0d",
                 pe, cmp_if.contagem, cmp_if.passos);
        n_checks++;
        if (pe !== 9) begin
            n_fail++;
            $display("FAIL down_latency: pronto edge=%0d required 9", pe);
        end
        n_checks++;
        if (cmp_if.contagem !== 4'd2 || cmp_if.passos !== 4'd7) begin
            n_fail++;
            $display("FAIL down_values: contagem=%0d passos=%0d required 2/7",
                     cmp_if.contagem, cmp_if.passos);
        end
    endtask

    task automatic test_zero_distance();
        int pe;
        bit busy;
        run_seek(4'd2, pe, busy);
        $display("zero_distance: target=2 pronto_edge=%0d contagem=%0d passos=%0d",
                 pe, cmp_if.contagem, cmp_if.passos);
        n_checks++;
        if (pe !== 2) begin
            n_fail++;
            $display("FAIL zero_latency: pronto edge=%0d required 2", pe);
        end
        n_checks++;
        if (cmp_if.contagem !== 4'd2 || cmp_if.passos !== 4'd0) begin
            n_fail++;
            $display("FAIL zero_values: contagem=%0d passos=%0d required 2/0",
                     cmp_if.contagem, cmp_if.passos);
        end
    endtask

    task automatic test_abort();
        bit seen_pronto;
        bit reached;
        seen_pronto = 1'b0;
        reached     = 1'b0;
        do_reset();
        @(negedge clk);
        cmp_if.start = 1'b1;
        cmp_if.alvo  = 4'd12;
        @(posedge clk);
        #1;
        cmp_if.start = 1'b0;
        for (int e = 0; e < 30; e++) begin
            @(posedge clk);
            #1;
            if (cmp_if.pronto) seen_pronto = 1'b1;
            if (cmp_if.contagem == 4'd5) begin
                reached = 1'b1;
                break;
            end
        end
        @(negedge clk);
        cmp_if.abort = 1'b1;
        @(posedge clk);
        #1;
        cmp_if.abort = 1'b0;
        repeat (3) begin
            @(posedge clk);
            #1;
            if (cmp_if.pronto) seen_pronto = 1'b1;
        end
        $display("abort: reached5=%b contagem=%0d ocupado=%b pronto_seen=%b",
                 reached, cmp_if.contagem, cmp_if.ocupado, seen_pronto);
        n_checks++;
        if (reached !== 1'b1 || cmp_if.contagem !== 4'd5 || cmp_if.passos !== 4'd5) begin
            n_fail++;
            $display("FAIL abort_hold: reached=%b contagem=%0d passos=%0d required 1/5/5",
                     reached, cmp_if.contagem, cmp_if.passos);
        end
        n_checks++;
        if (cmp_if.ocupado !== 1'b0 || seen_pronto !== 1'b0) begin
            n_fail++;
            $display("FAIL abort_idle: ocupado=%b pronto_seen=%b required 0/0",
                     cmp_if.ocupado, seen_pronto);
        end
        // start and abort together: abort wins
        @(negedge clk);
        cmp_if.start = 1'b1;
        cmp_if.abort = 1'b1;
        cmp_if.alvo  = 4'd1;
        @(posedge clk);
        #1;
        cmp_if.start = 1'b0;
        cmp_if.abort = 1'b0;
        $display("start_abort: ocupado=%b alvo_reg=%0d", cmp_if.ocupado, cmp_if.alvo_reg);
        n_checks++;
        if (cmp_if.ocupado !== 1'b0 || cmp_if.alvo_reg !== 4'd12) begin
            n_fail++;
            $display("FAIL start_abort: ocupado=%b alvo_reg=%0d required 0/12",
                     cmp_if.ocupado, cmp_if.alvo_reg);
        end
    endtask

    task automatic test_erro_and_async_reset();
        int pe;
        bit busy;
        do_reset();
        @(negedge clk);
        cmp_if.start = 1'b1;
        cmp_if.alvo  = 4'd7;
        @(posedge clk);
        #1;
        cmp_if.start = 1'b0;
        repeat (4) @(posedge clk);   // CONTA, contagem now 3
        @(negedge clk);
        force_err = 1'b1;
        @(posedge clk);
        #1;
        force_err = 1'b0;
        $display("erro: erro=%b ocupado=%b contagem=%0d passos=%0d",
                 cmp_if.erro, cmp_if.ocupado, cmp_if.contagem, cmp_if.passos);
        n_checks++;
        if (cmp_if.erro !== 1'b1 || cmp_if.ocupado !== 1'b0 ||
            cmp_if.contagem !== 4'd3 || cmp_if.passos !== 4'd3) begin
            n_fail++;
            $display("FAIL erro_set: erro=%b ocupado=%b contagem=%0d passos=%0d required 1/0/3/3",
                     cmp_if.erro, cmp_if.ocupado, cmp_if.contagem, cmp_if.passos);
        end
        // A new start clears erro and finishes the run from contagem=3.
        run_seek(4'd7, pe, busy);
        $display("erro_clear: erro=%b pronto_edge=%0d contagem=%0d", cmp_if.erro, pe, cmp_if.contagem);
        n_checks++;
        if (cmp_if.erro !== 1'b0 || pe !== 6 || cmp_if.contagem !== 4'd7) begin
            n_fail++;
            $display("FAIL erro_clear: erro=%b pronto_edge=%0d contagem=%0d required 0/6/7",
                     cmp_if.erro, pe, cmp_if.contagem);
        end
        // Reset mid-run, between clock edges.
        @(negedge clk);
        cmp_if.start = 1'b1;
        cmp_if.alvo  = 4'd0;
        @(posedge clk);
        #1;
        cmp_if.start = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        $display("async_reset: contagem=%0d alvo_reg=%0d passos=%0d ocupado=%b",
                 cmp_if.contagem, cmp_if.alvo_reg, cmp_if.passos, cmp_if.ocupado);
        n_checks++;
        if ({cmp_if.contagem, cmp_if.alvo_reg, cmp_if.passos} !== 12'h000 ||
            {cmp_if.ocupado, cmp_if.pronto, cmp_if.erro} !== 3'b000) begin
            n_fail++;
            $display("FAIL async_reset: contagem=%0d alvo_reg=%0d passos=%0d ocupado=%b, required all 0",
                     cmp_if.contagem, cmp_if.alvo_reg, cmp_if.passos, cmp_if.ocupado);
        end
        rst_n = 1'b1;
    endtask

    initial begin
        n_checks     = 0;
        n_fail       = 0;
        force_err    = 1'b0;
        rst_n        = 1'b1;
        cmp_if.start = 1'b0;
        cmp_if.abort = 1'b0;
        cmp_if.alvo  = 4'd0;
        test_reset();
        test_count_up();
        test_count_down();
        test_zero_distance();
        test_abort();
        test_erro_and_async_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
